div_fu_ctrl: RTL
================

Name: div_fu_ctrl

Overview:
- Divide functional-unit controller for the out-of-order core.
- Accepts one RV32M divide/remainder op at a time from the divide reservation station and resolves the RISC-V special cases locally.
- Converts signed operands to magnitudes and drives the unsigned sequential divider (tc_mode 0, input_mode 0, output_mode 0).
- Restores the result sign and presents the result to the CDB arbiter on a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; equals divider a/b width.
- ROB_IDX_W, 5, ROB tag width.
- PREG_W, 6, physical destination register index width.
- NUM_CYC, 32, divider cycle count; informational, used only by assertions (max BUSY length NUM_CYC+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (mispredict); kills the in-flight op
- issue_valid  in  1  RS presents op
- issue_ready  out  1  unit can accept op
- issue_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- issue_rs1_v  in  XLEN  dividend
- issue_rs2_v  in  XLEN  divisor
- issue_rob_id  in  ROB_IDX_W  ROB tag
- issue_pd  in  PREG_W  physical destination
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  XLEN  unsigned dividend magnitude, registered, held stable
- div_b  out  XLEN  unsigned divisor magnitude, registered, held stable
- div_hold  out  1  tied 0
- div_complete  in  1  divider complete
- div_quotient  in  XLEN  unsigned quotient
- div_remainder  in  XLEN  unsigned remainder
- res_valid  out  1  result ready for CDB
- res_ready  in  1  CDB grant
- res_data  out  XLEN  final result
- res_rob_id  out  ROB_IDX_W  tag
- res_pd  out  PREG_W  destination

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0 except issue_ready=1; operand/tag registers 0. Reset mid-operation abandons the op; no result is emitted.
- issue_ready = (state==IDLE). Accept = issue_valid & issue_ready & ~flush. On accept, latch funct3, rob_id, pd, raw operands.
- Sign handling: signed = ~funct3[0]. neg_a = signed & rs1[XLEN-1]; neg_b = signed & rs2[XLEN-1]. div_a = neg_a ? -rs1 : rs1; div_b likewise.
- Final result: q_neg = neg_a ^ neg_b; r_neg = neg_a. Apply two's-complement negation per the flag to the divider output; funct3[1] selects remainder.
- Special cases, decided on accept; the divider is not started:
  - divisor == 0: quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF): quotient = 0x8000_0000; remainder = 0.
- States:
  - IDLE: on accept -> DONE if special case (result latched), else START.
  - START: div_start=1 for exactly this cycle -> BUSY.
  - BUSY: wait for div_complete=1 (sampled from the cycle after START onward). On complete, latch sign-fixed result -> DONE.
  - DONE: res_valid=1; res_data/rob_id/pd stable until res_ready. On res_valid & res_ready -> IDLE.
  - DRAIN: wait for div_complete=1 -> IDLE; no result.
- Latency: special case 1 cycle accept-to-res_valid; normal NUM_CYC+2 cycles nominal.
- Flush:
  - In START or BUSY -> DRAIN. DRAIN keeps div_a/div_b stable.
  - In DONE -> IDLE; result dropped; res_valid deasserts the next cycle.
  - In IDLE, the issue is ignored.
  - Flush takes priority over res_ready and div_complete in the same cycle.
- res_valid is never asserted in IDLE, START, BUSY or DRAIN. No back-to-back accept; the next accept is possible in the cycle after the DONE handshake.

Decomposition:
- Shared package div_pkg:
  - funct3 encodings DIV/DIVU/REM/REMU.
  - state enum {IDLE, START, BUSY, DONE, DRAIN}.
  - Packed struct div_req_t {funct3, rs1_v, rs2_v, rob_id, pd}.
- One combinational sub-module, div_sign_fix: raw result + neg flags + funct3 -> final XLEN result. It is reused for the special-case path.

Test Plan:
- DIV 100 / 7 -> res_data 14 after NUM_CYC+2 cycles; DIVU, REMU 100 / 7 -> 14, 2.
- DIV -7 / 2 -> 0xFFFF_FFFD (-3); REM -7 / 2 -> 0xFFFF_FFFF (-1); REM 7 / -2 -> 1.
- DIVU 5 / 0 -> 0xFFFF_FFFF; REM 5 / 0 -> 5; both res_valid one cycle after accept, div_start never pulses.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0; no div_start.
- res_ready held 0 for 10 cycles in DONE -> res_valid/res_data/rob_id stable, issue_ready=0 throughout.
- Flush 5 cycles into BUSY -> DRAIN, no res_valid, issue_ready returns after div_complete. The next DIVU 9/3 -> 3. Also cover rst mid-BUSY -> outputs at reset values next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the RV32M divide functional-unit controller.
// Struct field widths follow the DIV_* defaults; keep the controller parameters equal to them.
package div_pkg;

    localparam int DIV_XLEN   = 32;
    localparam int DIV_ROB_W  = 5;
    localparam int DIV_PREG_W = 6;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DONE,
        DRAIN
    } div_state_e;

    typedef struct packed {
        logic [2:0]            funct3;
        logic [DIV_XLEN-1:0]   rs1_v;
        logic [DIV_XLEN-1:0]   rs2_v;
        logic [DIV_ROB_W-1:0]  rob_id;
        logic [DIV_PREG_W-1:0] pd;
    } div_req_t;

    // Two's-complement magnitude of a value that is known to be negative when neg=1.
    function automatic logic [DIV_XLEN-1:0] mag(input logic neg, input logic [DIV_XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Restores the sign of an unsigned divide result and selects quotient or remainder.
// Shared by the divider-return path and the locally resolved special cases.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            i_is_rem,
    input  logic [XLEN-1:0] i_quot,
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_q_neg,
    input  logic            i_r_neg,
    output logic [XLEN-1:0] o_result
);

    always_comb begin
        if (i_is_rem) o_result = i_r_neg ? -i_rem : i_rem;
        else          o_result = i_q_neg ? -i_quot : i_quot;
    end

endmodule

// File: rtl/div_fu_ctrl.sv
// Divide FU controller: accepts one RV32M div/rem op, resolves special cases locally,
// runs the unsigned sequential divider otherwise, and returns a sign-corrected result.
module div_fu_ctrl
    import div_pkg::*;
#(
    parameter int XLEN      = DIV_XLEN,
    parameter int ROB_IDX_W = DIV_ROB_W,
    parameter int PREG_W    = DIV_PREG_W,
    parameter int NUM_CYC   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           issue_funct3,
    input  logic [XLEN-1:0]      issue_rs1_v,
    input  logic [XLEN-1:0]      issue_rs2_v,
    input  logic [ROB_IDX_W-1:0] issue_rob_id,
    input  logic [PREG_W-1:0]    issue_pd,
    output logic                 div_start,
    output logic [XLEN-1:0]      div_a,
    output logic [XLEN-1:0]      div_b,
    output logic                 div_hold,
    input  logic                 div_complete,
    input  logic [XLEN-1:0]      div_quotient,
    input  logic [XLEN-1:0]      div_remainder,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [XLEN-1:0]      res_data,
    output logic [ROB_IDX_W-1:0] res_rob_id,
    output logic [PREG_W-1:0]    res_pd
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      r_state, w_state_nxt;
    div_req_t        r_req, w_req_in;
    logic [XLEN-1:0] r_div_a, r_div_b, r_res_data;

    logic            w_accept, w_signed, w_neg_a, w_neg_b;
    logic            w_div0, w_ovf, w_special;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic [XLEN-1:0] w_sp_quot, w_sp_rem, w_sp_res;
    logic            w_sp_q_neg;
    logic            w_dv_neg_a, w_dv_neg_b;
    logic [XLEN-1:0] w_dv_res;
    logic            w_unused;

    assign w_accept = issue_valid & (r_state == IDLE) & ~flush;

    // Operand decode on the issue side
    assign w_signed  = ~issue_funct3[0];
    assign w_neg_a   = w_signed & issue_rs1_v[XLEN-1];
    assign w_neg_b   = w_signed & issue_rs2_v[XLEN-1];
    assign w_mag_a   = mag(w_neg_a, issue_rs1_v);
    assign w_mag_b   = mag(w_neg_b, issue_rs2_v);
    assign w_div0    = (issue_rs2_v == '0);
    assign w_ovf     = w_signed & (issue_rs1_v == MIN_INT) & (issue_rs2_v == '1);
    assign w_special = w_div0 | w_ovf;

    // Special cases expressed as magnitudes so the common sign fixer yields the RISC-V result:
    // x/0 -> quotient all ones (never negated), remainder = |x| re-signed to x.
    // MIN/-1 -> |MIN| = MIN with both operands negative, so the quotient stays MIN; remainder 0.
    assign w_sp_quot  = w_div0 ? '1 : w_mag_a;
    assign w_sp_rem   = w_div0 ? w_mag_a : '0;
    assign w_sp_q_neg = w_div0 ? 1'b0 : (w_neg_a ^ w_neg_b);

    div_sign_fix #(.XLEN(XLEN)) u_sp_fix (
        .i_is_rem (issue_funct3[1]),
        .i_quot   (w_sp_quot),
        .i_rem    (w_sp_rem),
        .i_q_neg  (w_sp_q_neg),
        .i_r_neg  (w_neg_a),
        .o_result (w_sp_res)
    );

    // Divider-return path; sign flags come from the latched raw operands
    assign w_dv_neg_a = ~r_req.funct3[0] & r_req.rs1_v[XLEN-1];
    assign w_dv_neg_b = ~r_req.funct3[0] & r_req.rs2_v[XLEN-1];

    div_sign_fix #(.XLEN(XLEN)) u_dv_fix (
        .i_is_rem (r_req.funct3[1]),
        .i_quot   (div_quotient),
        .i_rem    (div_remainder),
        .i_q_neg  (w_dv_neg_a ^ w_dv_neg_b),
        .i_r_neg  (w_dv_neg_a),
        .o_result (w_dv_res)
    );

    always_comb begin
        w_req_in        = '0;
        w_req_in.funct3 = issue_funct3;
        w_req_in.rs1_v  = issue_rs1_v;
        w_req_in.rs2_v  = issue_rs2_v;
        w_req_in.rob_id = issue_rob_id;
        w_req_in.pd     = issue_pd;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Flush wins over res_ready and div_complete; a started divide is always drained.
    always_comb begin
        w_state_nxt = r_state;
        issue_ready = 1'b0;
        div_start   = 1'b0;
        res_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                issue_ready = 1'b1;
                if (w_accept) w_state_nxt = w_special ? DONE : START;
            end
            START: begin
                div_start   = 1'b1;
                w_state_nxt = flush ? DRAIN : BUSY;
            end
            BUSY: begin
                if (flush)             w_state_nxt = DRAIN;
                else if (div_complete) w_state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (flush || res_ready) w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (div_complete) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req      <= '0;
            r_div_a    <= '0;
            r_div_b    <= '0;
            r_res_data <= '0;
        end else if (w_accept) begin
            r_req   <= w_req_in;
            r_div_a <= w_mag_a;
            r_div_b <= w_mag_b;
            if (w_special) r_res_data <= w_sp_res;
        end else if (r_state == BUSY && div_complete && !flush) begin
            r_res_data <= w_dv_res;
        end
    end

    assign div_a      = r_div_a;
    assign div_b      = r_div_b;
    assign div_hold   = 1'b0;
    assign res_data   = r_res_data;
    assign res_rob_id = r_req.rob_id;
    assign res_pd     = r_req.pd;

    assign w_unused = &{1'b0, issue_funct3[2], r_req.funct3[2],
                        r_req.rs1_v[XLEN-2:0], r_req.rs2_v[XLEN-2:0]};

`ifndef SYNTHESIS
    logic [15:0] r_busy_cyc;

    always_ff @(posedge clk) begin
        if (rst || r_state != BUSY) r_busy_cyc <= '0;
        else                        r_busy_cyc <= r_busy_cyc + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_busy_cyc <= 16'(NUM_CYC + 1))
                else $error("divider busy longer than NUM_CYC+1 cycles");
        end
    end

    a_start_pulse: assert property (@(posedge clk) disable iff (rst)
        div_start |=> !div_start);

    a_res_hold: assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready && !flush) |=>
        (res_valid && $stable(res_data) && $stable(res_rob_id) && $stable(res_pd)));
`endif

endmodule
